// File: rtl/cb_cfg_pkg.sv
// Shared sizing helpers and configuration field layout for the connection-block crossbar.
package cb_cfg_pkg;

  localparam int W_DEF = 5;
  localparam int O_DEF = 6;
  localparam int P_DEF = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // LB-input mux select width: picks one of 2W tracks
  function automatic int sl_of(input int w);
    return clog2(2 * w);
  endfunction

  // Track mux select width: opposite track or one of 2P logic-block outputs
  function automatic int st_of(input int p);
    return clog2(2 * p + 1);
  endfunction

  function automatic int cfg_len(input int w, input int o, input int p);
    return 2 * o * sl_of(w) + 2 * w * (st_of(p) + 1);
  endfunction

  // side 0 = LB1, side 1 = LB2; LB fields sit at the bottom of the word
  function automatic int lb_field_base(input int side, input int i, input int o, input int sl);
    return (side * o + i) * sl;
  endfunction

  // side 0 = CB1, side 1 = CB2; each track field is {REG, sel[ST-1:0]}
  function automatic int cb_field_base(input int side, input int i, input int w,
                                       input int o, input int sl, input int st);
    return 2 * o * sl + (side * w + i) * (st + 1);
  endfunction

endpackage

// File: rtl/cb_track_mux.sv
// N-input select mux with an always-running output flop; reg_en_i picks flop or bypass.
module cb_track_mux #(
  parameter int N  = 3,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  src_i,
  input  logic [SW-1:0] sel_i,
  input  logic          reg_en_i,
  output logic          y_o
);

  logic mux_d, mux_q;

  // Select one source; selects past the last source drive 0
  always_comb begin
    mux_d = 1'b0;
    for (int k = 0; k < N; k++)
      if (int'(sel_i) == k) mux_d = src_i[k];
  end

  // Flop samples every cycle so toggling REG glitches at most one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mux_q <= 1'b0;
    else        mux_q <= mux_d;
  end

  assign y_o = reg_en_i ? mux_q : mux_d;

endmodule

// File: rtl/cb_config_xbar.sv
// Connection block: track -> LB-input muxes, LB/track -> track muxes,
// double-buffered serial configuration with length-checked commit.
module cb_config_xbar
  import cb_cfg_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int O = O_DEF,
  parameter int P = P_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [P-1:0] LB1_IN,
  input  logic [P-1:0] LB2_IN,
  input  logic [W-1:0] CB1_IN,
  input  logic [W-1:0] CB2_IN,
  output logic [O-1:0] LB1_OUT,
  output logic [O-1:0] LB2_OUT,
  output logic [W-1:0] CB1_OUT,
  output logic [W-1:0] CB2_OUT,
  input  logic         CFG_EN,
  input  logic         CFG_IN,
  output logic         CFG_OUT,
  input  logic         CFG_COMMIT,
  output logic         CFG_VALID,
  output logic         CFG_ERR
);

  localparam int SL = sl_of(W);
  localparam int ST = st_of(P);
  localparam int L  = cfg_len(W, O, P);
  localparam int CW = clog2(L + 2);

  logic [L-1:0]  shadow_q, shadow_d;
  logic [L-1:0]  active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Shift/count/commit control; commit always clears the bit counter
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (CFG_EN) begin
      shadow_d = {shadow_q[L-2:0], CFG_IN};
      if (cnt_q != CW'(L + 1)) cnt_d = cnt_q + CW'(1);
    end
    if (CFG_COMMIT) begin
      cnt_d = '0;
      if (!CFG_EN && cnt_q == CW'(L)) begin
        active_d = shadow_q;
        valid_d  = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Configuration state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  logic [2*W-1:0] lb_src;
  logic [O-1:0]   lb1_mux, lb2_mux;
  logic [W-1:0]   cb1_mux, cb2_mux;

  assign lb_src = {CB2_IN, CB1_IN};

  for (genvar i = 0; i < O; i++) begin : g_lb
    localparam int B1 = lb_field_base(0, i, O, SL);
    localparam int B2 = lb_field_base(1, i, O, SL);
    cb_track_mux #(.N(2*W), .SW(SL)) u_lb1 (
      .clk(CLK), .rst_n(RST_N), .src_i(lb_src), .sel_i(active_q[B1 +: SL]),
      .reg_en_i(1'b0), .y_o(lb1_mux[i]));
    cb_track_mux #(.N(2*W), .SW(SL)) u_lb2 (
      .clk(CLK), .rst_n(RST_N), .src_i(lb_src), .sel_i(active_q[B2 +: SL]),
      .reg_en_i(1'b0), .y_o(lb2_mux[i]));
  end

  // Track source order: 0 = opposite-direction track, then LB1 outputs, then LB2 outputs
  for (genvar i = 0; i < W; i++) begin : g_cb
    localparam int B1 = cb_field_base(0, i, W, O, SL, ST);
    localparam int B2 = cb_field_base(1, i, W, O, SL, ST);
    cb_track_mux #(.N(2*P+1), .SW(ST)) u_cb1 (
      .clk(CLK), .rst_n(RST_N), .src_i({LB2_IN, LB1_IN, CB2_IN[i]}),
      .sel_i(active_q[B1 +: ST]), .reg_en_i(active_q[B1+ST]), .y_o(cb1_mux[i]));
    cb_track_mux #(.N(2*P+1), .SW(ST)) u_cb2 (
      .clk(CLK), .rst_n(RST_N), .src_i({LB2_IN, LB1_IN, CB1_IN[i]}),
      .sel_i(active_q[B2 +: ST]), .reg_en_i(active_q[B2+ST]), .y_o(cb2_mux[i]));
  end

  // Nothing drives the fabric until a configuration has been accepted
  assign LB1_OUT   = valid_q ? lb1_mux : '0;
  assign LB2_OUT   = valid_q ? lb2_mux : '0;
  assign CB1_OUT   = valid_q ? cb1_mux : '0;
  assign CB2_OUT   = valid_q ? cb2_mux : '0;
  assign CFG_OUT   = shadow_q[L-1];
  assign CFG_VALID = valid_q;
  assign CFG_ERR   = err_q;

endmodule

// File: tb/tb_cb_config_xbar.sv
// Directed bench for cb_config_xbar at default sizing (W=5, O=6, P=1, L=78).
module tb_cb_config_xbar;

  logic       clk, rst_n;
  logic [0:0] lb1_in, lb2_in;
  logic [4:0] cb1_in, cb2_in;
  logic [5:0] lb1_out, lb2_out;
  logic [4:0] cb1_out, cb2_out;
  logic       cfg_en, cfg_in, cfg_out, cfg_commit, cfg_valid, cfg_err;
  int         n_chk, n_fail;

  localparam logic [9:0] OOB_PATS [5] = '{10'h3FF, 10'h155, 10'h2AA, 10'h000, 10'h3E1};
  localparam logic [77:0] VB = 78'h2B5C_3F10_8E7D_A965_0C41;
  localparam logic [77:0] VC = 78'h3C00_0000_0000_0000_00A5;

  cb_config_xbar dut (
    .CLK(clk), .RST_N(rst_n), .LB1_IN(lb1_in), .LB2_IN(lb2_in),
    .CB1_IN(cb1_in), .CB2_IN(cb2_in), .LB1_OUT(lb1_out), .LB2_OUT(lb2_out),
    .CB1_OUT(cb1_out), .CB2_OUT(cb2_out), .CFG_EN(cfg_en), .CFG_IN(cfg_in),
    .CFG_OUT(cfg_out), .CFG_COMMIT(cfg_commit), .CFG_VALID(cfg_valid), .CFG_ERR(cfg_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Send the low n bits of v MSB-first
  task automatic shift_vec(input logic [77:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      cfg_en = 1'b1; cfg_in = v[k];
      @(posedge clk); #1;
    end
    cfg_en = 1'b0; cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lb1_in = 1'b1; lb2_in = 1'b1; cb1_in = 5'h1F; cb2_in = 5'h1F;
    cfg_en = 1'b1; cfg_in = 1'b1; cfg_commit = 1'b1;
    #12;
    n_chk++; if ({lb1_out, lb2_out, cb1_out, cb2_out} !== 22'h0) begin n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {lb1_out, lb2_out, cb1_out, cb2_out}); end
    n_chk++; if ({cfg_valid, cfg_err, cfg_out} !== 3'b000) begin n_fail++;
      $display("FAIL reset_cfg_flags: got %b want 000", {cfg_valid, cfg_err, cfg_out}); end
    @(posedge clk); #1;
    cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({cfg_valid, lb1_out, cb1_out} !== 12'h0) begin n_fail++;
      $display("FAIL unconfigured_gated: got %h want 0", {cfg_valid, lb1_out, cb1_out}); end
  endtask

  task automatic test_lb_mux();
    logic [77:0] v;
    v = '0; v[3:0] = 4'd7;
    lb1_in = 1'b0; lb2_in = 1'b0; cb1_in = 5'h00; cb2_in = 5'b00100;
    shift_vec(v, 78);
    n_chk++; if (cfg_valid !== 1'b0 || lb1_out !== 6'h0) begin n_fail++;
      $display("FAIL precommit_invalid: got valid=%b lb1=%b want 0", cfg_valid, lb1_out); end
    commit();
    @(negedge clk);
    n_chk++; if ({cfg_valid, cfg_err} !== 2'b10) begin n_fail++;
      $display("FAIL commit_flags: got %b want 10", {cfg_valid, cfg_err}); end
    n_chk++; if (lb1_out !== 6'b000001) begin n_fail++;
      $display("FAIL lb1_mux0_sel7: got %b want 000001", lb1_out); end
    n_chk++; if ({cb1_out, cb2_out, lb2_out} !== {5'b00100, 5'b00000, 6'b000000}) begin n_fail++;
      $display("FAIL default_tracks_a: got %b want 0010000000000000", {cb1_out, cb2_out, lb2_out}); end
    cb1_in = 5'b00001; cb2_in = 5'h00;
    @(negedge clk);
    n_chk++; if ({lb1_out, lb2_out} !== {6'b111110, 6'b111111}) begin n_fail++;
      $display("FAIL lb_sel0_cb1: got %b want 111110111111", {lb1_out, lb2_out}); end
    n_chk++; if ({cb1_out, cb2_out} !== {5'b00000, 5'b00001}) begin n_fail++;
      $display("FAIL default_tracks_b: got %b want 0000000001", {cb1_out, cb2_out}); end
  endtask

  task automatic test_len_err();
    logic [77:0] v;
    v = '0; v[3:0] = 4'd1;
    cb1_in = 5'h00; cb2_in = 5'b00100;
    shift_vec(v, 77);
    commit();
    @(negedge clk);
    n_chk++; if ({cfg_valid, cfg_err} !== 2'b11) begin n_fail++;
      $display("FAIL short_load_err: got %b want 11", {cfg_valid, cfg_err}); end
    n_chk++; if (lb1_out !== 6'b000001) begin n_fail++;
      $display("FAIL short_load_keeps_active: got %b want 000001", lb1_out); end
    shift_vec(v, 78);
    commit();
    @(negedge clk);
    n_chk++; if ({cfg_valid, cfg_err, lb1_out} !== {2'b10, 6'b000000}) begin n_fail++;
      $display("FAIL reload_ok: got %b want 10000000", {cfg_valid, cfg_err, lb1_out}); end
    cb1_in = 5'b00010; cb2_in = 5'h00;
    @(negedge clk);
    n_chk++; if (lb1_out !== 6'b000001) begin n_fail++;
      $display("FAIL lb1_mux0_sel1: got %b want 000001", lb1_out); end
  endtask

  task automatic test_reg_track();
    logic [77:0] v;
    v = '0; v[57] = 1'b1; v[59] = 1'b1;
    lb1_in = 1'b0; lb2_in = 1'b0; cb1_in = 5'h00; cb2_in = 5'h00;
    shift_vec(v, 78);
    commit();
    @(posedge clk); #1;
    lb1_in = 1'b1;
    @(negedge clk);
    n_chk++; if (cb1_out !== 5'b00000) begin n_fail++;
      $display("FAIL reg_rise_same_cycle: got %b want 00000", cb1_out); end
    @(negedge clk);
    n_chk++; if (cb1_out !== 5'b01000) begin n_fail++;
      $display("FAIL reg_rise_next_cycle: got %b want 01000", cb1_out); end
    @(posedge clk); #1;
    lb1_in = 1'b0;
    @(negedge clk);
    n_chk++; if (cb1_out !== 5'b01000) begin n_fail++;
      $display("FAIL reg_fall_same_cycle: got %b want 01000", cb1_out); end
    @(negedge clk);
    n_chk++; if (cb1_out !== 5'b00000) begin n_fail++;
      $display("FAIL reg_fall_next_cycle: got %b want 00000", cb1_out); end
    v[59] = 1'b0;
    shift_vec(v, 78);
    commit();
    lb1_in = 1'b1; #1;
    n_chk++; if (cb1_out !== 5'b01000) begin n_fail++;
      $display("FAIL comb_rise: got %b want 01000", cb1_out); end
    lb1_in = 1'b0; #1;
    n_chk++; if (cb1_out !== 5'b00000) begin n_fail++;
      $display("FAIL comb_fall: got %b want 00000", cb1_out); end
  endtask

  task automatic test_oob();
    logic [77:0] v;
    v = '0; v[47:44] = 4'd12;
    shift_vec(v, 78);
    commit();
    for (int k = 0; k < 5; k++) begin
      {cb2_in, cb1_in} = OOB_PATS[k];
      @(negedge clk);
      n_chk++; if (lb2_out !== {1'b0, {5{OOB_PATS[k][0]}}}) begin n_fail++;
        $display("FAIL lb2_mux5_oob[%0d]: got %b want %b", k, lb2_out, {1'b0, {5{OOB_PATS[k][0]}}}); end
      n_chk++; if (cb2_out !== OOB_PATS[k][4:0]) begin n_fail++;
        $display("FAIL cb2_pass[%0d]: got %b want %b", k, cb2_out, OOB_PATS[k][4:0]); end
    end
  endtask

  task automatic test_commit_en_chain();
    logic [77:0] model;
    cb1_in = 5'h1F; cb2_in = 5'h1F;
    shift_vec('0, 78);
    cfg_en = 1'b1; cfg_in = 1'b0; cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_en = 1'b0; cfg_commit = 1'b0;
    @(negedge clk);
    n_chk++; if ({cfg_err, lb2_out} !== {1'b1, 6'b011111}) begin n_fail++;
      $display("FAIL commit_with_en_rejected: got %b want 1011111", {cfg_err, lb2_out}); end
    shift_vec('0, 78);
    commit();
    @(negedge clk);
    n_chk++; if ({cfg_err, lb2_out} !== {1'b0, 6'b111111}) begin n_fail++;
      $display("FAIL counter_cleared: got %b want 0111111", {cfg_err, lb2_out}); end
    model = '0;
    for (int k = 0; k < 156; k++) begin
      cfg_en = 1'b1;
      cfg_in = (k < 78) ? VB[77-k] : VC[155-k];
      model = {model[76:0], cfg_out};
      @(posedge clk); #1;
    end
    cfg_en = 1'b0; cfg_in = 1'b0;
    n_chk++; if (model !== VB) begin n_fail++;
      $display("FAIL daisy_chain: got %h want %h", model, VB); end
    n_chk++; if (cfg_out !== 1'b1) begin n_fail++;
      $display("FAIL cfg_out_msb: got %b want 1", cfg_out); end
    commit();
    @(negedge clk);
    n_chk++; if ({cfg_err, lb2_out} !== {1'b1, 6'b111111}) begin n_fail++;
      $display("FAIL saturated_count_rejected: got %b want 1111111", {cfg_err, lb2_out}); end
  endtask

  task automatic test_async_reset();
    logic [77:0] v;
    cfg_en = 1'b1; cfg_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if ({cfg_out, cfg_valid} !== 2'b11) begin n_fail++;
      $display("FAIL pre_reset_state: got %b want 11", {cfg_out, cfg_valid}); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({cfg_valid, cfg_err, cfg_out} !== 3'b000) begin n_fail++;
      $display("FAIL async_reset_flags: got %b want 000", {cfg_valid, cfg_err, cfg_out}); end
    n_chk++; if ({lb1_out, lb2_out, cb1_out, cb2_out} !== 22'h0) begin n_fail++;
      $display("FAIL async_reset_outputs: got %h want 0", {lb1_out, lb2_out, cb1_out, cb2_out}); end
    cfg_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = '0; v[3:0] = 4'd7;
    cb1_in = 5'h00; cb2_in = 5'b00100;
    shift_vec(v, 78);
    commit();
    @(negedge clk);
    n_chk++; if ({cfg_valid, cfg_err, lb1_out} !== {2'b10, 6'b000001}) begin n_fail++;
      $display("FAIL post_reset_load: got %b want 10000001", {cfg_valid, cfg_err, lb1_out}); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    test_lb_mux();
    test_len_err();
    test_reg_track();
    test_oob();
    test_commit_en_chain();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cb_config_xbar.md
Name: cb_config_xbar

Overview:
- Parametrised successor to the scan-configured FPGA connection block.
- Routes the routing-channel tracks (W per direction) into the inputs of the two adjacent logic blocks, and routes logic-block outputs or pass-through tracks onto the channel.
- New capabilities: a double-buffered configuration (serial shadow chain plus a commit), a length check on the serial load, and a per-track option to register the output.
- Sits between two logic tiles and is daisy-chained with them on the configuration scan path.

Parameters:
- W, 5, tracks per direction.
- O, 6, inputs per logic block.
- P, 1, outputs per logic block.
- SL, derived = clog2(2W), select width of each LB-input mux.
- ST, derived = clog2(2P+1), select width of each track mux.
- L, derived = 2*O*SL + 2*W*(ST+1), configuration length in bits (defaults: 78).

Ports:
- CLK  in  1  clock; everything is rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- LB1_IN  in  P  outputs of logic block 1.
- LB2_IN  in  P  outputs of logic block 2.
- CB1_IN  in  W  tracks arriving from direction 1.
- CB2_IN  in  W  tracks arriving from direction 2.
- LB1_OUT  out  O  inputs to logic block 1.
- LB2_OUT  out  O  inputs to logic block 2.
- CB1_OUT  out  W  tracks leaving toward direction 1.
- CB2_OUT  out  W  tracks leaving toward direction 2.
- CFG_EN  in  1  shift enable for the configuration chain.
- CFG_IN  in  1  serial configuration input.
- CFG_OUT  out  1  serial configuration output (MSB of shadow chain).
- CFG_COMMIT  in  1  single-cycle pulse: copy shadow into active.
- CFG_VALID  out  1  active configuration is loaded.
- CFG_ERR  out  1  sticky: last commit rejected.

Behaviour:
- Reset (async assert, sync release):
  - shadow, active, bit counter, output flops, CFG_VALID and CFG_ERR are all 0.
  - While CFG_VALID=0, all LB*_OUT and CB*_OUT are forced to 0.
- Shadow chain (L bits):
  - On CFG_EN=1: shadow <= {shadow[L-2:0], CFG_IN}; CFG_OUT = shadow[L-1], registered.
  - The stream is therefore MSB-first; the first bit shifted in ends at bit L-1.
  - Bit counter increments on each shift and saturates at L+1.
- Field layout (LSB upward):
  - LB1 mux i at [i*SL +: SL], then LB2 muxes.
  - Then CB1 track i as ST+1 bits: select in the low ST bits, REG flag in the MSB; then CB2 tracks.
- Commit, on a CFG_COMMIT cycle:
  - CFG_EN=0 and counter==L: active <= shadow, CFG_VALID <= 1, CFG_ERR <= 0.
  - Otherwise: active is unchanged and CFG_ERR <= 1; on a simultaneous CFG_EN the shift still happens.
  - Counter clears on every commit, accepted or rejected.
  - The shadow is never altered by a commit; CFG_OUT keeps streaming for the daisy chain.
- LB-input mux:
  - Source vector {CB2_IN, CB1_IN}; select s picks bit s.
  - s >= 2W drives 0.
  - Combinational, zero latency.
- Track mux, direction 1, track i:
  - Sources: index 0 = CB2_IN[i], 1..P = LB1_IN, P+1..2P = LB2_IN; s > 2P drives 0.
  - Direction 2 is symmetric with CB1_IN[i].
  - REG=0: combinational output.
  - REG=1: output comes from a flop sampling the mux every cycle (1-cycle latency). The flop resets to 0 and runs regardless of the REG flag, so switching the flag glitches at most one cycle.
- A new active configuration takes effect the cycle after the accepted commit edge.

Decomposition:
- Package cb_cfg_pkg holds:
  - the clog2 function;
  - SL, ST and L derivations;
  - field-offset functions lb_field_base(side,i) and cb_field_base(side,i).
- One sub-module, cb_track_mux (N-input select mux plus optional output flop, parameters N and SW). It is instantiated 2W times; the LB-input muxes reuse it with the REG flag tied 0.
- The load/commit control (counter, VALID/ERR) stays in the top module.

Test Plan (defaults, L=78):
- Reset, no load; drive every input to 1 → all outputs 0, CFG_VALID=0, CFG_OUT=0.
- Shift 78 bits setting LB1 mux0 sel=7, all else 0; commit; drive CB2_IN=5'b00100 → LB1_OUT[0]=1 next cycle, CFG_VALID=1, CFG_ERR=0.
- Shift 77 bits then commit → CFG_ERR=1, outputs unchanged. Then shift 78 bits and commit → CFG_ERR=0, new configuration active.
- Set CB1 track 3 to sel=1 (LB1_IN[0]) with REG=1; toggle LB1_IN[0] → CB1_OUT[3] follows exactly 1 cycle later. With REG=0 it follows the same cycle.
- LB2 mux5 sel=12 (out of range) → LB2_OUT[5]=0 for every input pattern.
- Assert CFG_COMMIT together with CFG_EN after 78 shifts → rejected, ERR=1, counter=0. Then shift 156 bits with CFG_OUT looped through a 78-bit model chain → model chain receives the original stream. Assert RST_N mid-shift → all state 0 immediately.
